// File: rtl/univ_shift_register.sv
// N-bit universal shift register: shift, rotate, arithmetic shift, load and clear,
// plus a counted burst engine that repeats one shift/rotate op burst_len times.
module univ_shift_register #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [N-1:0]     pdata,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [N-1:0]     Q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_LOAD = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_d;
    op_t              burst_mode, burst_mode_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [N-1:0]     q_d;

    function automatic logic [N-1:0] apply_op(input op_t op, input logic [N-1:0] q,
                                              input logic smsb, input logic slsb,
                                              input logic [N-1:0] pd);
        logic [N-1:0] r;
        r = q;
        case (op)
            OP_SHR:  r = {smsb, q[N-1:1]};
            OP_SHL:  r = {q[N-2:0], slsb};
            OP_ROR:  r = {q[0], q[N-1:1]};
            OP_ROL:  r = {q[N-2:0], q[N-1]};
            OP_LOAD: r = pd;
            OP_ASR:  r = {q[N-1], q[N-1:1]};
            OP_CLR:  r = '0;
            default: r = q;
        endcase
        return r;
    endfunction

    function automatic logic is_burstable(input op_t op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state;
        burst_mode_d = burst_mode;
        cnt_d        = cnt;
        q_d          = Q;
        case (state)
            IDLE: begin
                if (en) begin
                    if (burst_start && is_burstable(op_t'(mode))) begin
                        burst_mode_d = op_t'(mode);
                        cnt_d        = burst_len;
                        state_d      = (burst_len == '0) ? DONE : BUSY;
                    end else begin
                        q_d = apply_op(op_t'(mode), Q, sin_msb, sin_lsb, pdata);
                    end
                end
            end
            BUSY: begin
                if (en) begin
                    q_d   = apply_op(burst_mode, Q, sin_msb, sin_lsb, pdata);
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_d = DONE;
                end
            end
            // DONE always returns to IDLE, even with en low, so done is a single pulse
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // pre-edge values, matching the hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            burst_mode <= OP_HOLD;
            cnt        <= '0;
            Q          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            burst_mode <= burst_mode_d;
            cnt        <= cnt_d;
            Q          <= q_d;
            busy       <= (state_d == BUSY);
            done       <= (state_d == DONE);
        end
    end

    assign sout_msb = Q[N-1];
    assign sout_lsb = Q[0];

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register (N=8, CNT_W=4): an arithmetic
// reference model compared every cycle, plus directed literal checkpoints.
module tb_univ_shift_register;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int MASK  = (1 << N) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic             sin_msb = 1'b0;
    logic             sin_lsb = 1'b0;
    logic [N-1:0]     pdata = '0;
    logic             burst_start = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic [N-1:0]     Q;
    logic             sout_msb, sout_lsb, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_register #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .pdata(pdata),
        .burst_start(burst_start), .burst_len(burst_len),
        .Q(Q), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register value as an integer, burst as "operations remaining".
    int m_q, m_rem, m_op;
    bit m_busy, m_done;

    function automatic int model_op(input int op, input int q, input int smsb,
                                    input int slsb, input int pd);
        case (op)
            1: return (q >> 1) + smsb * (1 << (N - 1));
            2: return ((q * 2) & MASK) + slsb;
            3: return (q >> 1) + (q % 2) * (1 << (N - 1));
            4: return ((q * 2) & MASK) + (q >> (N - 1));
            5: return pd;
            6: return (q >> 1) + (q & (1 << (N - 1)));
            7: return 0;
            default: return q;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q = 0; m_rem = 0; m_op = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (en) begin
            if (m_busy) begin
                m_q   = model_op(m_op, m_q, sin_msb, sin_lsb, pdata);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 0; m_done = 1; end
            end else if (burst_start && mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6}) begin
                m_op  = mode;
                m_rem = burst_len;
                if (m_rem == 0) m_done = 1; else m_busy = 1;
            end else begin
                m_q = model_op(mode, m_q, sin_msb, sin_lsb, pdata);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_q",    Q,        m_q);
        check("cyc_busy", busy,     m_busy);
        check("cyc_done", done,     m_done);
        check("cyc_smsb", sout_msb, (m_q >> (N - 1)) & 1);
        check("cyc_slsb", sout_lsb, m_q & 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0] v);
        mode = 3'b101; pdata = v; burst_start = 1'b0; en = 1'b1;
        tick();
    endtask

    initial begin
        // Reset held for two cycles
        tick(); tick();
        check("rst_q", Q, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;

        load(8'hA5);
        check("load_a5", Q, 8'hA5);
        mode = 3'b001; sin_msb = 1'b1; tick();
        check("shr", Q, 8'hD2);
        load(8'hA5);
        mode = 3'b100; tick();
        check("rol", Q, 8'h4B);
        load(8'h90);
        mode = 3'b110; tick();
        check("asr", Q, 8'hC8);
        load(8'h80);
        check("smsb_pre", sout_msb, 1'b1);
        mode = 3'b010; sin_lsb = 1'b1; tick();
        check("shl", Q, 8'h01);
        en = 1'b0; mode = 3'b111; tick();
        check("en_hold", Q, 8'h01);

        // Rotate-right burst of 3; mode changes during busy are ignored
        load(8'hA5);
        mode = 3'b011; burst_len = 4'd3; burst_start = 1'b1; tick();
        check("b_acc_q", Q, 8'hA5);
        check("b_acc_busy", busy, 1'b1);
        burst_start = 1'b0; mode = 3'b111; tick();
        check("b1", Q, 8'hD2);
        mode = 3'b101; pdata = 8'hFF; tick();
        check("b2", Q, 8'h69);
        check("b2_busy", busy, 1'b1);
        tick();
        check("b3", Q, 8'hB4);
        check("b3_busy", busy, 1'b0);
        check("b3_done", done, 1'b1);
        mode = 3'b000; tick();
        check("b_idle_done", done, 1'b0);
        check("b_idle_q", Q, 8'hB4);

        // Burst paused by en=0 for two cycles
        load(8'hA5);
        mode = 3'b011; burst_len = 4'd3; burst_start = 1'b1; tick();
        burst_start = 1'b0; tick();
        check("p1", Q, 8'hD2);
        en = 1'b0; tick(); tick();
        check("p_hold_q", Q, 8'hD2);
        check("p_hold_busy", busy, 1'b1);
        en = 1'b1; tick();
        check("p2", Q, 8'h69);
        tick();
        check("p3", Q, 8'hB4);
        check("p3_done", done, 1'b1);
        mode = 3'b000; tick();

        // Zero-length burst
        load(8'hA5);
        mode = 3'b001; burst_len = 4'd0; burst_start = 1'b1; tick();
        check("z_q", Q, 8'hA5);
        check("z_busy", busy, 1'b0);
        check("z_done", done, 1'b1);
        burst_start = 1'b0; mode = 3'b000; tick();
        check("z_done_end", done, 1'b0);

        // burst_start with load mode is a plain load
        mode = 3'b101; pdata = 8'h3C; burst_len = 4'd4; burst_start = 1'b1; tick();
        check("ld_q", Q, 8'h3C);
        check("ld_busy", busy, 1'b0);
        burst_start = 1'b0; mode = 3'b000;

        // Asynchronous reset mid-burst
        load(8'hA5);
        mode = 3'b010; sin_lsb = 1'b0; burst_len = 4'd5; burst_start = 1'b1; tick();
        burst_start = 1'b0; tick();
        check("r1", Q, 8'h4A);
        tick();
        check("r2", Q, 8'h94);
        #2 rst = 1'b0;
        #1;
        check("ar_q", Q, 8'h00);
        check("ar_busy", busy, 1'b0);
        check("ar_done", done, 1'b0);
        tick();
        rst = 1'b1;
        load(8'h81);
        mode = 3'b011; burst_len = 4'd2; burst_start = 1'b1; tick();
        check("nb_acc_busy", busy, 1'b1);
        burst_start = 1'b0; mode = 3'b000; tick();
        check("nb1", Q, 8'hC0);
        tick();
        check("nb2", Q, 8'h60);
        check("nb_done", done, 1'b1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
